uart_core_param: RTL and testbench
==================================

# uart_core_param

Parametrised UART top level that succeeds the fixed 16-byte UART core: it instantiates the existing `baud_gen`, `uart_tx` and `uart_rx` and wraps them with its own depth-configurable TX and RX buffers. It adds a per-byte parity tag in the RX buffer, sticky overrun detection and fill-level outputs. It also provides RTS flow control with hysteresis, a programmable RX interrupt threshold and an RX character timeout. It sits between the CPU register file and the serial pads.

## Interface
- `FIFO_AW`, 4: buffer address width; depth D = 2^FIFO_AW for both TX and RX.
- `RTS_ON_LEVEL`, 2^FIFO_AW-2: RX level at or above which RTS deasserts (`o_rts_n`=1).
- `RTS_OFF_LEVEL`, 2^(FIFO_AW-1): RX level at or below which RTS reasserts (`o_rts_n`=0); must be < `RTS_ON_LEVEL`.
- `TO_BITS`, 40: RX timeout length, counted in bit periods (`tx_tick` pulses).
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_divisor` in 16: baud divisor passed to `baud_gen`.
- `i_num_bit_data` in 2: data bits; 00=5, 01=6, 10=7, 11=8.
- `i_parity_en` in 1: enables parity generation and checking.
- `i_parity_type` in 1: 0=even, 1=odd.
- `i_rx_trig_level` in FIFO_AW+1: RX interrupt threshold.
- `i_cpu_txd` in 8: TX write data.
- `i_tx_wr` in 1: TX push, one byte per asserted cycle.
- `o_tx_full` out 1: TX level == D.
- `o_tx_level` out FIFO_AW+1: TX occupancy, 0..D.
- `o_cpu_rxd` out 8: RX head byte (first-word-fall-through).
- `o_rx_parity_err` out 1: parity tag of the RX head byte.
- `i_rx_rd` in 1: RX pop.
- `o_rx_empty` out 1: RX level == 0.
- `o_rx_level` out FIFO_AW+1: RX occupancy, 0..D.
- `o_overrun` out 1: sticky; a received byte was dropped.
- `i_clr_overrun` in 1: clears `o_overrun`.
- `o_irq_rx` out 1: RX level at or above the trigger, or timeout.
- `o_rx_timeout` out 1: RX timeout status.
- `o_irq_tx_empty` out 1: TX level == 0.
- `o_pedev_txd` out 1: serial TX.
- `i_pedev_rxd` in 1: serial RX.
- `i_cts_n` in 1: clear-to-send, active low; passed to `uart_tx`.
- `o_rts_n` out 1: request-to-send, active low; registered.

## Operation
- TX buffer: 8-bit circular buffer with read/write pointers of FIFO_AW bits, wrapping D-1 -> 0, plus a count register.
  - `uart_tx` `i_tx_start` = TX not empty; `uart_tx` `o_tx_done` pops the TX buffer.
- RX buffer: 9-bit entries {parity_err, data}.
  - `uart_rx` `o_rx_done` pushes {`o_parity_err`, `o_data`}.
  - `o_cpu_rxd`/`o_rx_parity_err` show the head entry combinationally.
- Push when full:
  - TX: ignored; contents unchanged.
  - RX: byte dropped and `o_overrun` set.
- Pop when empty: ignored.
- Simultaneous push and pop:
  - Not full and not empty: both occur; level unchanged.
  - Full: both occur; no overrun.
  - Empty: push only.
- `o_overrun`: if set and clear occur in the same cycle, set wins.
- RTS: registered hysteresis.
  - Goes 1 when RX level >= `RTS_ON_LEVEL`.
  - Returns to 0 when RX level <= `RTS_OFF_LEVEL`.
  - Otherwise holds.
- `o_irq_rx` = (RX level >= max(`i_rx_trig_level`, 1)) OR `o_rx_timeout`.
  - A trigger value > D means the level term never fires.
- Timeout counter: counts `tx_tick` pulses while RX is not empty.
  - Cleared on RX push, RX pop, or RX empty.
  - When the count reaches `TO_BITS`, `o_rx_timeout` sets and the counter saturates.
  - `o_rx_timeout` clears on the next RX push, pop, or empty.

## Timing
- Reset values:
  - `o_tx_full`=0, `o_tx_level`=0, `o_irq_tx_empty`=1.
  - `o_rx_empty`=1, `o_rx_level`=0, `o_cpu_rxd`=0, `o_rx_parity_err`=0.
  - `o_overrun`=0, `o_irq_rx`=0, `o_rx_timeout`=0, `o_rts_n`=0, `o_pedev_txd`=1.
  - Buffer memories are reset to 0.
- Push or pop at edge N updates levels, flags and head outputs from cycle N+1.
- `o_rts_n` follows the level with 1 extra cycle of latency (N+2).
- `o_rx_timeout` asserts the cycle after the `TO_BITS`-th `tx_tick`.
- Reset mid-frame: all buffers flush, the TX line returns to 1, and any partial RX frame is discarded.
- Configuration inputs must be stable while frames are in flight.

## Configuration
- `UART_CORE_PARAM_TIMEOUT_EN` defined: timeout counter is built and `o_rx_timeout` behaves as above.
- Not defined: no counter is built; `o_rx_timeout` is tied 0 and `o_irq_rx` is level-only.

## Test plan
- Reset, then write 3 bytes 0x55/0xA3/0x0F, 8N1, divisor 2, CTS low -> all three serialised in order; `o_tx_level` 3 -> 0; `o_irq_tx_empty` returns to 1.
- Feed 16 frames into RX with FIFO_AW=4 and no reads -> `o_rts_n` rises one cycle after level 14. A 17th frame -> `o_overrun`=1 and the level stays 16. Reading down to 8 -> `o_rts_n`=0.
- RX full, with `o_rx_done` and `i_rx_rd` in the same cycle -> level stays 16, no overrun, head advances.
- 8E1, one frame with a corrupted parity bit followed by a good frame -> head tag 1 then 0, data intact.
- Trigger=4, feed 2 bytes, then idle with the macro defined -> `o_irq_rx`=0 until 40 `tx_tick`s, then 1. One read -> `o_rx_timeout`=0 and the counter restarts.
- Without the macro, same stimulus -> `o_irq_rx` remains 0.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: UART top with depth-configurable TX/RX buffers, RTS hysteresis and RX interrupt.
// Define UART_CORE_PARAM_TIMEOUT_EN to build the RX character-timeout counter.

module baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_divisor,
  output logic        o_rx_tick,
  output logic        o_tx_tick
);
  logic [15:0] div_cnt;
  logic [3:0]  os_cnt;
  // rx_tick is 16x oversample; tx_tick is one pulse per bit period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0; os_cnt <= '0; o_rx_tick <= 1'b0; o_tx_tick <= 1'b0;
    end else begin
      o_rx_tick <= 1'b0; o_tx_tick <= 1'b0;
      if (div_cnt + 16'd1 >= i_divisor) begin
        div_cnt   <= '0;
        o_rx_tick <= 1'b1;
        os_cnt    <= os_cnt + 4'd1;
        o_tx_tick <= (os_cnt == 4'd15);
      end else div_cnt <= div_cnt + 16'd1;
    end
endmodule

module uart_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  input  logic       i_cts_n,
  output logic       o_txd,
  output logic       o_tx_done
);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  tx_state_t  state, state_nx;
  logic [7:0] shreg, shreg_nx, data_m;
  logic [2:0] bit_cnt, bit_cnt_nx, last_bit;
  logic       par, par_nx, txd_nx, done_nx;

  assign last_bit = {1'b0, i_num_bit_data} + 3'd4;
  assign data_m   = i_data & (8'hFF >> (2'd3 - i_num_bit_data));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= T_IDLE; shreg <= '0; bit_cnt <= '0; par <= 1'b0;
      o_txd <= 1'b1; o_tx_done <= 1'b0;
    end else begin
      state <= state_nx; shreg <= shreg_nx; bit_cnt <= bit_cnt_nx; par <= par_nx;
      o_txd <= txd_nx; o_tx_done <= done_nx;
    end

  always_comb begin
    state_nx = state; shreg_nx = shreg; bit_cnt_nx = bit_cnt; par_nx = par;
    txd_nx = o_txd; done_nx = 1'b0;
    if (i_tick) begin
      case (state)
        T_IDLE: if (i_tx_start && !i_cts_n) begin
          state_nx = T_START; txd_nx = 1'b0; bit_cnt_nx = '0;
          shreg_nx = data_m; par_nx = ^data_m ^ i_parity_type;
        end
        T_START: begin state_nx = T_DATA; txd_nx = shreg[0]; shreg_nx = shreg >> 1; end
        T_DATA: if (bit_cnt == last_bit) begin
          state_nx = i_parity_en ? T_PAR : T_STOP;
          txd_nx   = i_parity_en ? par : 1'b1;
        end else begin
          bit_cnt_nx = bit_cnt + 3'd1; txd_nx = shreg[0]; shreg_nx = shreg >> 1;
        end
        T_PAR:  begin state_nx = T_STOP; txd_nx = 1'b1; end
        T_STOP: begin state_nx = T_IDLE; done_nx = 1'b1; end
        default: state_nx = T_IDLE;
      endcase
    end
  end
endmodule

module uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_rxd,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_rx_done
);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  rx_state_t  state, state_nx;
  logic [1:0] sync;
  logic [3:0] os_cnt, os_cnt_nx;
  logic [2:0] bit_cnt, bit_cnt_nx, last_bit;
  logic [7:0] shreg, shreg_nx, data_al;
  logic       rxd, perr, perr_nx, done_nx;

  assign rxd      = sync[1];
  assign last_bit = {1'b0, i_num_bit_data} + 3'd4;
  // bits enter at the MSB, so short words need right-aligning
  assign data_al  = shreg >> (2'd3 - i_num_bit_data);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11; state <= R_IDLE; os_cnt <= '0; bit_cnt <= '0; shreg <= '0;
      perr <= 1'b0; o_data <= '0; o_parity_err <= 1'b0; o_rx_done <= 1'b0;
    end else begin
      sync <= {sync[0], i_rxd};
      state <= state_nx; os_cnt <= os_cnt_nx; bit_cnt <= bit_cnt_nx;
      shreg <= shreg_nx; perr <= perr_nx; o_rx_done <= done_nx;
      if (done_nx) begin o_data <= data_al; o_parity_err <= perr; end
    end

  always_comb begin
    state_nx = state; os_cnt_nx = os_cnt; bit_cnt_nx = bit_cnt; shreg_nx = shreg;
    perr_nx = perr; done_nx = 1'b0;
    if (i_tick) begin
      os_cnt_nx = os_cnt + 4'd1;
      case (state)
        R_IDLE: begin
          os_cnt_nx = '0;
          if (!rxd) state_nx = R_START;
        end
        R_START: if (os_cnt == 4'd7) begin
          os_cnt_nx = '0; bit_cnt_nx = '0; perr_nx = 1'b0;
          state_nx = rxd ? R_IDLE : R_DATA;
        end
        R_DATA: if (os_cnt == 4'd15) begin
          shreg_nx   = {rxd, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == last_bit) state_nx = i_parity_en ? R_PAR : R_STOP;
        end
        R_PAR: if (os_cnt == 4'd15) begin
          perr_nx = ^data_al ^ rxd ^ i_parity_type; state_nx = R_STOP;
        end
        R_STOP: if (os_cnt == 4'd15) begin done_nx = 1'b1; state_nx = R_IDLE; end
        default: state_nx = R_IDLE;
      endcase
    end
  end
endmodule

module uart_core_param #(
  parameter int FIFO_AW       = 4,
  parameter int RTS_ON_LEVEL  = 2**FIFO_AW - 2,
  parameter int RTS_OFF_LEVEL = 2**(FIFO_AW-1),
  parameter int TO_BITS       = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        i_divisor,
  input  logic [1:0]         i_num_bit_data,
  input  logic               i_parity_en,
  input  logic               i_parity_type,
  input  logic [FIFO_AW:0]   i_rx_trig_level,
  input  logic [7:0]         i_cpu_txd,
  input  logic               i_tx_wr,
  output logic               o_tx_full,
  output logic [FIFO_AW:0]   o_tx_level,
  output logic [7:0]         o_cpu_rxd,
  output logic               o_rx_parity_err,
  input  logic               i_rx_rd,
  output logic               o_rx_empty,
  output logic [FIFO_AW:0]   o_rx_level,
  output logic               o_overrun,
  input  logic               i_clr_overrun,
  output logic               o_irq_rx,
  output logic               o_rx_timeout,
  output logic               o_irq_tx_empty,
  output logic               o_pedev_txd,
  input  logic               i_pedev_rxd,
  input  logic               i_cts_n,
  output logic               o_rts_n
);
  localparam int D  = 1 << FIFO_AW;
  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0]      DEPTH   = LW'(D);
  localparam logic [LW-1:0]      RTS_ON  = LW'(RTS_ON_LEVEL);
  localparam logic [LW-1:0]      RTS_OFF = LW'(RTS_OFF_LEVEL);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic               rx_tick, tx_tick, tx_done, rx_done, rx_perr;
  logic [7:0]         rx_data, tx_head;
  logic [7:0]         tx_mem [D];
  logic [8:0]         rx_mem [D];
  logic [FIFO_AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0]      tx_cnt, rx_cnt, trig_eff;
  logic               tx_empty, tx_push, tx_pop, rx_full, rx_push, rx_pop;

  baud_gen u_baud (.clk, .rst_n, .i_divisor, .o_rx_tick(rx_tick), .o_tx_tick(tx_tick));

  uart_tx u_tx (.clk, .rst_n, .i_tick(tx_tick), .i_tx_start(!tx_empty), .i_data(tx_head),
    .i_num_bit_data, .i_parity_en, .i_parity_type, .i_cts_n,
    .o_txd(o_pedev_txd), .o_tx_done(tx_done));

  uart_rx u_rx (.clk, .rst_n, .i_tick(rx_tick), .i_rxd(i_pedev_rxd), .i_num_bit_data,
    .i_parity_en, .i_parity_type, .o_data(rx_data), .o_parity_err(rx_perr),
    .o_rx_done(rx_done));

  // a push into a full buffer is accepted only when a pop frees the slot in the same cycle
  assign tx_empty = (tx_cnt == '0);
  assign tx_pop   = tx_done && !tx_empty;
  assign tx_push  = i_tx_wr && (!o_tx_full || tx_pop);
  assign rx_full  = (rx_cnt == DEPTH);
  assign rx_pop   = i_rx_rd && !o_rx_empty;
  assign rx_push  = rx_done && (!rx_full || rx_pop);

  assign tx_head        = tx_mem[tx_rp];
  assign o_tx_full      = (tx_cnt == DEPTH);
  assign o_tx_level     = tx_cnt;
  assign o_irq_tx_empty = tx_empty;
  assign {o_rx_parity_err, o_cpu_rxd} = rx_mem[rx_rp];
  assign o_rx_empty     = (rx_cnt == '0);
  assign o_rx_level     = rx_cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < D; i++) tx_mem[i] <= '0;
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_push) begin tx_mem[tx_wp] <= i_cpu_txd; tx_wp <= tx_wp + PTR_ONE; end
      if (tx_pop) tx_rp <= tx_rp + PTR_ONE;
      tx_cnt <= tx_cnt + LW'(tx_push) - LW'(tx_pop);
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < D; i++) rx_mem[i] <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0; o_overrun <= 1'b0; o_rts_n <= 1'b0;
    end else begin
      if (rx_push) begin rx_mem[rx_wp] <= {rx_perr, rx_data}; rx_wp <= rx_wp + PTR_ONE; end
      if (rx_pop) rx_rp <= rx_rp + PTR_ONE;
      rx_cnt <= rx_cnt + LW'(rx_push) - LW'(rx_pop);
      if (rx_done && !rx_push)  o_overrun <= 1'b1;
      else if (i_clr_overrun)   o_overrun <= 1'b0;
      if (rx_cnt >= RTS_ON)       o_rts_n <= 1'b1;
      else if (rx_cnt <= RTS_OFF) o_rts_n <= 1'b0;
    end

  assign trig_eff = (i_rx_trig_level == '0) ? LW'(1) : i_rx_trig_level;
  assign o_irq_rx = (rx_cnt >= trig_eff) || o_rx_timeout;

`ifdef UART_CORE_PARAM_TIMEOUT_EN
  localparam int TOW = $clog2(TO_BITS + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TO_BITS);
  logic [TOW-1:0] to_cnt;
  // saturates at TO_MAX; any buffer activity or an empty buffer restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                 to_cnt <= '0;
    else if (rx_push || rx_pop || o_rx_empty)   to_cnt <= '0;
    else if (tx_tick && to_cnt != TO_MAX)       to_cnt <= to_cnt + TOW'(1);
  assign o_rx_timeout = (to_cnt == TO_MAX);
`else
  assign o_rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param: TX serialisation, RX buffering, RTS, overrun, parity, timeout.
module tb_uart_core_param;
  localparam int AW  = 4;
  localparam int BIT = 32;   // divisor 2 x 16 oversample
  localparam int TO  = 40;
`ifdef UART_CORE_PARAM_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] i_divisor = 16'd2;
  logic [1:0]  i_num_bit_data = 2'b11;
  logic        i_parity_en = 1'b0, i_parity_type = 1'b0;
  logic [AW:0] i_rx_trig_level = 5'd4;
  logic [7:0]  i_cpu_txd = '0;
  logic        i_tx_wr = 1'b0, i_rx_rd = 1'b0, i_clr_overrun = 1'b0;
  logic        i_pedev_rxd = 1'b1, i_cts_n = 1'b0;
  logic        o_tx_full, o_rx_parity_err, o_rx_empty, o_overrun, o_irq_rx, o_rx_timeout;
  logic        o_irq_tx_empty, o_pedev_txd, o_rts_n;
  logic [AW:0] o_tx_level, o_rx_level;
  logic [7:0]  o_cpu_rxd;

  int tests = 0, fails = 0;
  logic [7:0] tx_q[$];
  logic [8:0] rx_q[$];

  always #5 clk = ~clk;

  uart_core_param #(.FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_divisor(i_divisor), .i_num_bit_data(i_num_bit_data),
    .i_parity_en(i_parity_en), .i_parity_type(i_parity_type), .i_rx_trig_level(i_rx_trig_level),
    .i_cpu_txd(i_cpu_txd), .i_tx_wr(i_tx_wr), .o_tx_full(o_tx_full), .o_tx_level(o_tx_level),
    .o_cpu_rxd(o_cpu_rxd), .o_rx_parity_err(o_rx_parity_err), .i_rx_rd(i_rx_rd),
    .o_rx_empty(o_rx_empty), .o_rx_level(o_rx_level), .o_overrun(o_overrun),
    .i_clr_overrun(i_clr_overrun), .o_irq_rx(o_irq_rx), .o_rx_timeout(o_rx_timeout),
    .o_irq_tx_empty(o_irq_tx_empty), .o_pedev_txd(o_pedev_txd), .i_pedev_rxd(i_pedev_rxd),
    .i_cts_n(i_cts_n), .o_rts_n(o_rts_n));

  task automatic do_reset();
    rst_n = 1'b0; i_tx_wr = 0; i_rx_rd = 0; i_clr_overrun = 0; i_pedev_rxd = 1'b1;
    i_parity_en = 0; i_parity_type = 0; i_rx_trig_level = 5'd4;
    tx_q.delete(); rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one 8-bit frame using the current parity configuration.
  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    i_pedev_rxd = 1'b0; repeat (BIT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin i_pedev_rxd = d[b]; repeat (BIT) @(negedge clk); end
    if (i_parity_en) begin
      i_pedev_rxd = ^d ^ i_parity_type ^ bad_par; repeat (BIT) @(negedge clk);
    end
    i_pedev_rxd = 1'b1; repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] obs, exp;
    int c;
    do_reset();
    obs = {o_tx_full, o_tx_level, o_irq_tx_empty, o_rx_empty, o_rx_level, o_cpu_rxd,
           o_rx_parity_err, o_overrun, o_irq_rx, o_rx_timeout, o_rts_n, o_pedev_txd};
    exp = {1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin fails++; $display("FAIL reset_values: got %h exp %h", obs, exp); end
    // reset in the middle of a frame
    i_cpu_txd = 8'hF0; i_tx_wr = 1; @(negedge clk); i_tx_wr = 0;
    c = 0;
    while (o_pedev_txd !== 1'b0 && c < 200) begin @(negedge clk); c++; end
    repeat (50) @(negedge clk);
    rst_n = 1'b0; #1;
    tests++;
    if ({o_pedev_txd, o_tx_level} !== {1'b1, 5'd0}) begin
      fails++; $display("FAIL reset_midframe: txd=%b lvl=%0d exp txd=1 lvl=0", o_pedev_txd, o_tx_level);
    end
    do_reset();
  endtask

  task automatic test_tx();
    logic [7:0] bytes [3];
    logic [7:0] got, exp;
    int c;
    bytes[0] = 8'h55; bytes[1] = 8'hA3; bytes[2] = 8'h0F;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_cpu_txd = bytes[k]; i_tx_wr = 1; tx_q.push_back(bytes[k]); @(negedge clk);
    end
    i_tx_wr = 0;
    tests++;
    if ({o_tx_level, o_irq_tx_empty} !== {5'd3, 1'b0}) begin
      fails++; $display("FAIL tx_level3: lvl=%0d empty=%b exp 3/0", o_tx_level, o_irq_tx_empty);
    end
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (o_pedev_txd !== 1'b0 && c < 2000) begin @(negedge clk); c++; end
      if (c >= 2000) begin
        tests++; fails++; $display("FAIL tx_start_wait: frame %0d never started", k); break;
      end
      repeat (BIT/2) @(negedge clk);
      tests++;
      if (o_pedev_txd !== 1'b0) begin fails++; $display("FAIL tx_start_bit: got %b exp 0", o_pedev_txd); end
      for (int b = 0; b < 8; b++) begin repeat (BIT) @(negedge clk); got[b] = o_pedev_txd; end
      repeat (BIT) @(negedge clk);
      tests++;
      if (o_pedev_txd !== 1'b1) begin fails++; $display("FAIL tx_stop_bit: got %b exp 1", o_pedev_txd); end
      exp = tx_q.pop_front();
      tests++;
      if (got !== exp) begin fails++; $display("FAIL tx_data%0d: got %h exp %h", k, got, exp); end
    end
    c = 0;
    while (o_tx_level !== 5'd0 && c < 500) begin @(negedge clk); c++; end
    tests++;
    if ({o_tx_level, o_irq_tx_empty} !== {5'd0, 1'b1}) begin
      fails++; $display("FAIL tx_drained: lvl=%0d empty=%b exp 0/1", o_tx_level, o_irq_tx_empty);
    end
  endtask

  task automatic test_rx_fill();
    logic [7:0] d;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      d = 8'(k * 17) ^ 8'hA5;
      rx_q.push_back({1'b0, d});
      if (k == 13) begin
        fork
          send_frame(d, 1'b0);
          begin : w14
            int c;
            c = 0;
            while (o_rx_level !== 5'd14 && c < 2000) begin @(negedge clk); c++; end
            tests++;
            if (c >= 2000) begin fails++; $display("FAIL rts_watch: level 14 not seen, lvl=%0d", o_rx_level); end
            else begin
              if (o_rts_n !== 1'b0) begin fails++; $display("FAIL rts_at14: got %b exp 0", o_rts_n); end
              @(negedge clk);
              tests++;
              if (o_rts_n !== 1'b1) begin fails++; $display("FAIL rts_after14: got %b exp 1", o_rts_n); end
            end
          end
        join
      end else send_frame(d, 1'b0);
    end
    tests++;
    if ({o_rx_level, o_rts_n, o_irq_rx, o_overrun} !== {5'd16, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL rx_full16: lvl=%0d rts=%b irq=%b ovr=%b exp 16/1/1/0",
                        o_rx_level, o_rts_n, o_irq_rx, o_overrun);
    end
    send_frame(8'hEE, 1'b0);
    tests++;
    if ({o_overrun, o_rx_level} !== {1'b1, 5'd16}) begin
      fails++; $display("FAIL rx_overrun: ovr=%b lvl=%0d exp 1/16", o_overrun, o_rx_level);
    end
    i_clr_overrun = 1; @(negedge clk); i_clr_overrun = 0;
    tests++;
    if (o_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b exp 0", o_overrun); end
  endtask

  task automatic test_full_simul();
    logic [8:0] exp;
    exp = rx_q.pop_front();
    tests++;
    if ({o_rx_parity_err, o_cpu_rxd} !== exp) begin
      fails++; $display("FAIL simul_head_before: got %h exp %h", {o_rx_parity_err, o_cpu_rxd}, exp);
    end
    rx_q.push_back({1'b0, 8'h3C});
    fork
      send_frame(8'h3C, 1'b0);
      begin : wdone
        int c;
        c = 0;
        while (dut.rx_done !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
        if (c >= 2000) begin tests++; fails++; $display("FAIL simul_wait: rx_done not seen"); end
        i_rx_rd = 1; @(negedge clk); i_rx_rd = 0;
      end
    join
    tests++;
    if ({o_rx_level, o_overrun, o_cpu_rxd} !== {5'd16, 1'b0, rx_q[0][7:0]}) begin
      fails++; $display("FAIL simul_full: lvl=%0d ovr=%b head=%h exp 16/0/%h",
                        o_rx_level, o_overrun, o_cpu_rxd, rx_q[0][7:0]);
    end
  endtask

  task automatic test_rx_drain();
    logic [8:0] exp;
    for (int k = 0; k < 16; k++) begin
      exp = rx_q.pop_front();
      tests++;
      if ({o_rx_parity_err, o_cpu_rxd} !== exp) begin
        fails++; $display("FAIL drain%0d: got %h exp %h", k, {o_rx_parity_err, o_cpu_rxd}, exp);
      end
      i_rx_rd = 1; @(negedge clk); i_rx_rd = 0;
      if (k == 7) begin
        tests++;
        if ({o_rx_level, o_rts_n} !== {5'd8, 1'b1}) begin
          fails++; $display("FAIL rts_hold8: lvl=%0d rts=%b exp 8/1", o_rx_level, o_rts_n);
        end
        @(negedge clk);
        tests++;
        if (o_rts_n !== 1'b0) begin fails++; $display("FAIL rts_release: got %b exp 0", o_rts_n); end
      end
    end
    tests++;
    if ({o_rx_empty, o_rx_level} !== {1'b1, 5'd0}) begin
      fails++; $display("FAIL drain_empty: empty=%b lvl=%0d exp 1/0", o_rx_empty, o_rx_level);
    end
  endtask

  task automatic test_parity();
    logic [8:0] exp;
    do_reset();
    i_parity_en = 1; i_parity_type = 0;
    send_frame(8'h5A, 1'b1); rx_q.push_back({1'b1, 8'h5A});
    send_frame(8'h3C, 1'b0); rx_q.push_back({1'b0, 8'h3C});
    i_parity_type = 1;
    send_frame(8'h81, 1'b0); rx_q.push_back({1'b0, 8'h81});
    for (int k = 0; k < 3; k++) begin
      exp = rx_q.pop_front();
      tests++;
      if ({o_rx_parity_err, o_cpu_rxd} !== exp) begin
        fails++; $display("FAIL parity%0d: got %h exp %h", k, {o_rx_parity_err, o_cpu_rxd}, exp);
      end
      i_rx_rd = 1; @(negedge clk); i_rx_rd = 0;
    end
  endtask

  task automatic test_timeout();
    logic [8:0] exp;
    logic early, late;
    int n, c;
    do_reset();
    send_frame(8'h11, 1'b0); rx_q.push_back({1'b0, 8'h11});
    rx_q.push_back({1'b0, 8'h22});
    early = 0; n = 0;
    fork
      send_frame(8'h22, 1'b0);
      begin : wcount
        c = 0;
        while (o_rx_level !== 5'd2 && c < 2000) begin @(negedge clk); c++; end
        for (int i = 0; i < 4000 && n < TO; i++) begin
          if (o_rx_timeout !== 1'b0 || o_irq_rx !== 1'b0) early = 1;
          if (dut.tx_tick === 1'b1) n++;
          if (n < TO) @(negedge clk);
        end
      end
    join
    tests++;
    if (early !== 1'b0 || n != TO) begin
      fails++; $display("FAIL to_before: early=%b ticks=%0d exp 0/%0d", early, n, TO);
    end
    @(negedge clk);
    tests++;
    if ({o_rx_timeout, o_irq_rx} !== {TO_EN, TO_EN}) begin
      fails++; $display("FAIL to_fire: to=%b irq=%b exp %b/%b", o_rx_timeout, o_irq_rx, TO_EN, TO_EN);
    end
    repeat (10 * BIT) @(negedge clk);
    tests++;
    if ({o_rx_timeout, o_irq_rx} !== {TO_EN, TO_EN}) begin
      fails++; $display("FAIL to_saturate: to=%b irq=%b exp %b/%b", o_rx_timeout, o_irq_rx, TO_EN, TO_EN);
    end
    exp = rx_q.pop_front();
    tests++;
    if ({o_rx_parity_err, o_cpu_rxd} !== exp) begin
      fails++; $display("FAIL to_head: got %h exp %h", {o_rx_parity_err, o_cpu_rxd}, exp);
    end
    i_rx_rd = 1; @(negedge clk); i_rx_rd = 0;
    tests++;
    if ({o_rx_timeout, o_irq_rx, o_rx_level} !== {1'b0, 1'b0, 5'd1}) begin
      fails++; $display("FAIL to_clear: to=%b irq=%b lvl=%0d exp 0/0/1", o_rx_timeout, o_irq_rx, o_rx_level);
    end
    late = 0; n = 0;
    for (int i = 0; i < 2000 && n < 20; i++) begin
      if (o_rx_timeout !== 1'b0) late = 1;
      if (dut.tx_tick === 1'b1) n++;
      @(negedge clk);
    end
    tests++;
    if (late !== 1'b0) begin fails++; $display("FAIL to_restart: timeout=1 within 20 ticks, exp 0"); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_fill();
    test_full_simul();
    test_rx_drain();
    test_parity();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end
endmodule
